q_update_ctrl: RTL
==================

Name: q_update_ctrl

Overview:
- Sequencer that runs one complete Q-learning update per accepted request.
- Reads Q(s,a) from the Q-table RAM, scans all NUM_ACTIONS entries of the next state to find max Q(s',·), and drives the q_updater datapath.
- Writes q_new back to Q(s,a).
- Sits between the episode/agent logic (request side) and the single-port-read/single-port-write Q-table plus the q_updater instance.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single-precision word width.
- STATE_W, 4, state index width; NUM_STATES = 2**STATE_W.
- ACTION_W, 2, action index width; NUM_ACTIONS = 2**ACTION_W.
- UPD_LAT, 1, number of cycles upd_valid is held before upd_q_new is sampled (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  update request
- req_ready  out  1  controller idle, can accept
- req_state  in  STATE_W  current state s
- req_action  in  ACTION_W  action a
- req_next_state  in  STATE_W  next state s'
- req_reward  in  DATA_WIDTH  reward rt (FP32)
- mem_rd_en  out  1  Q-table read strobe
- mem_rd_addr  out  STATE_W+ACTION_W  read address = {state, action}
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  Q-table write strobe
- mem_wr_addr  out  STATE_W+ACTION_W  write address = {s, a}
- mem_wr_data  out  DATA_WIDTH  q_new
- upd_q  out  DATA_WIDTH  to q_updater q
- upd_max_q  out  DATA_WIDTH  to q_updater max_q
- upd_rt  out  DATA_WIDTH  to q_updater rt
- upd_valid  out  1  to q_updater valid_in
- upd_q_new  in  DATA_WIDTH  from q_updater q_new
- done  out  1  one-cycle pulse, coincident with mem_wr_en
- busy  out  1  high in every state except IDLE
- update_count  out  16  completed updates, wraps 0xFFFF→0x0000

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0 except req_ready=1. The FSM goes to IDLE.
- Accept: a request is accepted on a cycle where req_valid && req_ready (cycle 0). s, a, s' and rt are latched; req_ready drops the next cycle.
- FSM states: IDLE → RD_Q → RD_MAX → RD_WAIT → UPDATE → WRITE → IDLE.
- RD_Q (cycle 1): mem_rd_en=1, addr={s,a}.
- RD_MAX (cycles 2..NUM_ACTIONS+1): mem_rd_en=1, addr={s',k}, k=0..NUM_ACTIONS-1 ascending.
- Data capture: Q(s,a) is captured at cycle 2. Candidate k is captured at cycle k+3.
- RD_WAIT (cycle NUM_ACTIONS+2): captures the last candidate; mem_rd_en=0.
- UPDATE: lasts UPD_LAT cycles. upd_valid=1, and upd_q, upd_max_q, upd_rt are held stable. upd_q_new is sampled on the last UPDATE cycle.
- WRITE (1 cycle): mem_wr_en=1, addr={s,a}, data=sampled q_new. done=1 and update_count++ in the same cycle.
- Return to IDLE: the FSM returns to IDLE on the next cycle, with req_ready=1 again.
- Latency: accept to done = NUM_ACTIONS+3+UPD_LAT cycles (8 with defaults). Throughput is one update per NUM_ACTIONS+4+UPD_LAT cycles.
- Max comparator: FP32 sign-magnitude compare, no FP units.
  - Both non-negative: larger magnitude wins. Both negative: smaller magnitude wins. Mixed signs: the positive value wins.
  - +0 and -0 compare equal.
  - On ties the earlier (lower k) value is kept.
  - NaN/Inf inputs are not supported; the result for them is undefined but the FSM must still complete.
- Output hold: upd_q, upd_max_q and upd_rt keep their last values when outside UPDATE. upd_valid=0 outside UPDATE.
- s' == s: reads still occur. No write happens before the reads, so the pre-update values are used.
- req_valid while busy: ignored, not queued. The requester must hold it until req_ready.
- rst mid-operation: the FSM aborts to IDLE on the next edge. No mem_wr_en is issued for the aborted request, and update_count is unchanged. Request inputs are re-latched on the next accept.

Optional Feature:
- Macro: Q_TERMINAL_EN.
- Defined:
  - Adds input port req_terminal (1 bit), latched at accept.
  - If req_terminal=1, RD_MAX and RD_WAIT are skipped (RD_Q → RD_QWAIT 1 cycle → UPDATE), upd_max_q=32'h00000000, and latency = 3+UPD_LAT.
  - If req_terminal=0, behaviour is identical to the base.
- Undefined: the port is absent and every request performs the full next-state scan.

Test Plan:
- Basic: table 0, Q(3,0..3)={3F800000,40000000,3F000000,BF800000}; req s=1,a=2,s'=3,rt=3F800000; bench drives upd_q_new=12345678 → upd_q=0, upd_max_q=40000000, upd_rt=3F800000, mem_wr_addr=6, mem_wr_data=12345678, done at cycle 8, update_count=1.
- All-negative: Q(5,·)={BF800000,C0400000,C0000000,BF000000} → upd_max_q=BF000000.
- Signed zero tie: Q(2,·)={80000000,00000000,BF800000,C0000000} → upd_max_q=80000000 (first kept).
- Back-to-back: req_valid held high with two requests → req_ready=0 cycles 1..8, second accepted at cycle 9, its done at cycle 17, update_count=2, exactly two mem_wr_en pulses.
- Reset mid-op: rst=1 at cycle 4 → no mem_wr_en, all outputs at reset values, update_count=0; the next request completes normally.
- Q_TERMINAL_EN defined: req_terminal=1 → exactly one mem_rd_en pulse, upd_max_q=00000000, done at cycle 4.

Source files
------------

// File: rtl/q_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// q_update_ctrl_if
// Bundles every non-clock signal of q_update_ctrl: the request handshake from
// the agent, the Q-table read/write ports, the q_updater datapath hookup and
// the status outputs.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The requester keeps req_valid and the request fields
// stable until that edge; req_valid seen while req_ready=0 is not queued.
//
// Modports:
//   slave  - the controller (q_update_ctrl)
//   master - the environment (agent, Q-table RAM, q_updater)
//
// Optional macro Q_TERMINAL_EN adds the req_terminal request field.
// -----------------------------------------------------------------------------
interface q_update_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int STATE_W    = 4,
   parameter int ACTION_W   = 2
);
   // request side
   logic                        req_valid;
   logic                        req_ready;
   logic [STATE_W-1:0]          req_state;
   logic [ACTION_W-1:0]         req_action;
   logic [STATE_W-1:0]          req_next_state;
   logic [DATA_WIDTH-1:0]       req_reward;
`ifdef Q_TERMINAL_EN
   logic                        req_terminal;
`endif
   // Q-table
   logic                        mem_rd_en;
   logic [STATE_W+ACTION_W-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0]       mem_rd_data;
   logic                        mem_wr_en;
   logic [STATE_W+ACTION_W-1:0] mem_wr_addr;
   logic [DATA_WIDTH-1:0]       mem_wr_data;
   // q_updater
   logic [DATA_WIDTH-1:0]       upd_q;
   logic [DATA_WIDTH-1:0]       upd_max_q;
   logic [DATA_WIDTH-1:0]       upd_rt;
   logic                        upd_valid;
   logic [DATA_WIDTH-1:0]       upd_q_new;
   // status
   logic                        done;
   logic                        busy;
   logic [15:0]                 update_count;

   modport slave (
`ifdef Q_TERMINAL_EN
      input  req_terminal,
`endif
      input  req_valid, req_state, req_action, req_next_state, req_reward,
      input  mem_rd_data, upd_q_new,
      output req_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
      output mem_wr_data, upd_q, upd_max_q, upd_rt, upd_valid,
      output done, busy, update_count
   );

   modport master (
`ifdef Q_TERMINAL_EN
      output req_terminal,
`endif
      output req_valid, req_state, req_action, req_next_state, req_reward,
      output mem_rd_data, upd_q_new,
      input  req_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
      input  mem_wr_data, upd_q, upd_max_q, upd_rt, upd_valid,
      input  done, busy, update_count
   );
endinterface

// File: rtl/q_update_ctrl.sv
// -----------------------------------------------------------------------------
// q_update_ctrl
// Runs one Q-learning update per accepted request: reads Q(s,a), scans the
// NUM_ACTIONS entries of next state s' for max Q(s',.), presents q/max_q/rt to
// the q_updater for UPD_LAT cycles, then writes q_new back to Q(s,a).
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - q_update_ctrl_if.slave: request handshake, Q-table read/write,
//          q_updater hookup, done/busy/update_count status
//
// Sequence (cycle 0 = accept):
//   1       RD_Q    read {s,a}
//   2..N+1  RD_MAX  read {s',k}, k ascending; Q(s,a) captured at cycle 2
//   N+2     RD_WAIT capture last candidate
//   UPD_LAT UPDATE  upd_valid=1, q_new sampled on last cycle
//   1       WRITE   mem_wr_en, done, update_count++
//
// Optional macro Q_TERMINAL_EN: adds req_terminal; a terminal request skips
// the next-state scan (RD_Q -> RD_QWAIT -> UPDATE) and uses max_q = +0.
// -----------------------------------------------------------------------------
module q_update_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int STATE_W    = 4,
   parameter int ACTION_W   = 2,
   parameter int UPD_LAT    = 1
) (
   input  logic           clk,
   input  logic           rst,
   q_update_ctrl_if.slave bus
);
   localparam int NUM_ACTIONS = 2 ** ACTION_W;
   localparam int LAT_W       = (UPD_LAT > 1) ? $clog2(UPD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE, RD_Q, RD_QWAIT, RD_MAX, RD_WAIT, UPDATE, WRITE
   } state_t;

   state_t                state;
   logic [STATE_W-1:0]    s_reg;
   logic [ACTION_W-1:0]   a_reg;
   logic [STATE_W-1:0]    sn_reg;
   logic [DATA_WIDTH-1:0] rt_reg;
   logic [DATA_WIDTH-1:0] q_reg;
   logic [DATA_WIDTH-1:0] max_reg;
   logic [ACTION_W-1:0]   k;
   logic [LAT_W-1:0]      lat_cnt;
`ifdef Q_TERMINAL_EN
   logic                  term_reg;
`endif

   // Sign-magnitude "strictly greater" so that ties (including +0 vs -0)
   // leave the earlier candidate in place.
   function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] x,
                                  input logic [DATA_WIDTH-1:0] y);
      logic                  xs, ys;
      logic [DATA_WIDTH-2:0] xm, ym;
      xs = x[DATA_WIDTH-1];
      ys = y[DATA_WIDTH-1];
      xm = x[DATA_WIDTH-2:0];
      ym = y[DATA_WIDTH-2:0];
      if (!xs && !ys)     return xm > ym;
      else if (xs && ys)  return xm < ym;
      else if (!xs && ys) return (xm != '0) || (ym != '0);
      else                return 1'b0;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         s_reg            <= '0;
         a_reg            <= '0;
         sn_reg           <= '0;
         rt_reg           <= '0;
         q_reg            <= '0;
         max_reg          <= '0;
         k                <= '0;
         lat_cnt          <= '0;
`ifdef Q_TERMINAL_EN
         term_reg         <= 1'b0;
`endif
         bus.req_ready    <= 1'b1;
         bus.busy         <= 1'b0;
         bus.mem_rd_en    <= 1'b0;
         bus.mem_rd_addr  <= '0;
         bus.mem_wr_en    <= 1'b0;
         bus.mem_wr_addr  <= '0;
         bus.mem_wr_data  <= '0;
         bus.upd_q        <= '0;
         bus.upd_max_q    <= '0;
         bus.upd_rt       <= '0;
         bus.upd_valid    <= 1'b0;
         bus.done         <= 1'b0;
         bus.update_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               // req_ready is 1 throughout IDLE, so req_valid alone accepts
               if (bus.req_valid) begin
                  s_reg           <= bus.req_state;
                  a_reg           <= bus.req_action;
                  sn_reg          <= bus.req_next_state;
                  rt_reg          <= bus.req_reward;
`ifdef Q_TERMINAL_EN
                  term_reg        <= bus.req_terminal;
`endif
                  bus.req_ready   <= 1'b0;
                  bus.busy        <= 1'b1;
                  bus.mem_rd_en   <= 1'b1;
                  bus.mem_rd_addr <= {bus.req_state, bus.req_action};
                  state           <= RD_Q;
               end
            end
            RD_Q: begin
`ifdef Q_TERMINAL_EN
               if (term_reg) begin
                  bus.mem_rd_en <= 1'b0;
                  state         <= RD_QWAIT;
               end else
`endif
               begin
                  bus.mem_rd_addr <= {sn_reg, {ACTION_W{1'b0}}};
                  k               <= '0;
                  state           <= RD_MAX;
               end
            end
            RD_QWAIT: begin
               q_reg         <= bus.mem_rd_data;
               bus.upd_q     <= bus.mem_rd_data;
               bus.upd_max_q <= '0;
               bus.upd_rt    <= rt_reg;
               bus.upd_valid <= 1'b1;
               lat_cnt       <= '0;
               state         <= UPDATE;
            end
            RD_MAX: begin
               // Read data lags the address by one cycle: at k=0 it is
               // Q(s,a), at k>=1 it is candidate k-1.
               if (k == '0)
                  q_reg <= bus.mem_rd_data;
               else if (k == ACTION_W'(1))
                  max_reg <= bus.mem_rd_data;
               else if (fp_gt(bus.mem_rd_data, max_reg))
                  max_reg <= bus.mem_rd_data;

               if (k == ACTION_W'(NUM_ACTIONS - 1)) begin
                  bus.mem_rd_en <= 1'b0;
                  state         <= RD_WAIT;
               end else begin
                  k               <= k + ACTION_W'(1);
                  bus.mem_rd_addr <= {sn_reg, k + ACTION_W'(1)};
               end
            end
            RD_WAIT: begin
               bus.upd_max_q <= fp_gt(bus.mem_rd_data, max_reg) ?
                                bus.mem_rd_data : max_reg;
               bus.upd_q     <= q_reg;
               bus.upd_rt    <= rt_reg;
               bus.upd_valid <= 1'b1;
               lat_cnt       <= '0;
               state         <= UPDATE;
            end
            UPDATE: begin
               if (lat_cnt == LAT_W'(UPD_LAT - 1)) begin
                  bus.upd_valid    <= 1'b0;
                  bus.mem_wr_en    <= 1'b1;
                  bus.mem_wr_addr  <= {s_reg, a_reg};
                  bus.mem_wr_data  <= bus.upd_q_new;
                  bus.done         <= 1'b1;
                  bus.update_count <= bus.update_count + 16'd1;
                  state            <= WRITE;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            WRITE: begin
               bus.mem_wr_en <= 1'b0;
               bus.done      <= 1'b0;
               bus.busy      <= 1'b0;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
